// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder: single-outstanding load/store with fixed latency
// Rejects misaligned, out-of-range and illegal-width requests without touching memory.
module dm_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_bytes,
  input  logic        req_write,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            bytes_q;
  logic                  write_q;
  logic                  signed_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem [DEPTH];

  logic                  reject;
  logic [1:0]            bytes_m1;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           rd_shift;
  logic [31:0]           load_ext;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign word_idx   = addr_q[ADDR_WIDTH+1:2];
  assign lane       = addr_q[1:0];
  assign commit     = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    bytes_m1 = req_bytes[1:0] - 2'd1;
    reject   = (|(bytes_m1 & req_addr[1:0])) ||
               (|req_addr[31:ADDR_WIDTH+2]) ||
               !((req_bytes == 3'd1) || (req_bytes == 3'd2) || (req_bytes == 3'd4));
  end

  always_comb begin
    rd_shift = mem[word_idx] >> {lane, 3'b000};
    case (bytes_q)
      3'd1:    load_ext = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
      3'd2:    load_ext = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Replicate the narrow store data across the word; the byte enables pick the lanes.
  always_comb begin
    case (bytes_q)
      3'd1: begin
        wr_data = {4{wdata_q[7:0]}};
        wr_be   = 4'b0001 << lane;
      end
      3'd2: begin
        wr_data = {2{wdata_q[15:0]}};
        wr_be   = 4'b0011 << {lane[1], 1'b0};
      end
      default: begin
        wr_data = wdata_q;
        wr_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = reject ? RESP : BUSY;
      BUSY:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      bytes_q    <= 3'd0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr[ADDR_WIDTH+1:0];
            bytes_q    <= req_bytes;
            write_q    <= req_write;
            signed_q   <= req_signed;
            wdata_q    <= req_wdata;
            cnt        <= 4'(LATENCY - 1);
            resp_rdata <= 32'd0;
            resp_error <= reject;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else resp_rdata <= write_q ? 32'd0 : load_ext;
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - self-checking bench for dm_responder
// Directed table, randomized traffic against a byte-array reference, reset-abort sequence.
module tb_dm_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_bytes;
  logic        req_write;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem_m [256];

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  bytes;
    logic        wr;
    logic        sg;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t vt [15];

  dm_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_bytes(req_bytes), .req_write(req_write), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, checks and extension from plain arithmetic.
  task automatic model(input logic [31:0] a, input int b, input logic w, input logic s,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    longint v;
    er = !(b == 1 || b == 2 || b == 4);
    if (!er) er = ((a % b) != 0) || (a >= (32'd1 << (AW + 2)));
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < b; i++) mem_m[int'(a) + i] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < b; i++) v += longint'(mem_m[int'(a) + i]) << (8 * i);
        if (s && b < 4 && v >= (64'd1 << (8 * b - 1))) v -= (64'd1 << (8 * b));
        rd = v[31:0];
      end
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [2:0] b, input logic w, input logic s,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_addr = a; req_bytes = b; req_write = w; req_signed = s; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_rdata", resp_rdata, rd);
      check("hold_error", {31'd0, resp_error}, {31'd0, er});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat;
    int          b;
    logic [31:0] a;
    int          illegal_w [5] = '{0, 3, 5, 6, 7};

    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_bytes = '0; req_write = 1'b0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", {31'd0, resp_error}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) mem_m[i] = 8'd0;
    for (int w = 0; w < 64; w++) begin
      do_req(32'(w * 4), 3'd4, 1'b1, 1'b0, 32'd0, 0, rd, er, lat);
      check("init_err", {31'd0, er}, 32'd0);
    end

    vt[0]  = '{32'h10, 3'd4, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{32'h10, 3'd4, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{32'h21, 3'd1, 1'b1, 1'b0, 32'h80,       32'h0,        1'b0};
    vt[3]  = '{32'h21, 3'd1, 1'b0, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[4]  = '{32'h21, 3'd1, 1'b0, 1'b0, 32'h0,        32'h00000080, 1'b0};
    vt[5]  = '{32'h20, 3'd4, 1'b0, 1'b0, 32'h0,        32'h00008000, 1'b0};
    vt[6]  = '{32'h32, 3'd2, 1'b1, 1'b0, 32'h1234,     32'h0,        1'b0};
    vt[7]  = '{32'h32, 3'd2, 1'b0, 1'b1, 32'h0,        32'h00001234, 1'b0};
    vt[8]  = '{32'h30, 3'd2, 1'b1, 1'b0, 32'hF00D,     32'h0,        1'b0};
    vt[9]  = '{32'h30, 3'd2, 1'b0, 1'b1, 32'h0,        32'hFFFFF00D, 1'b0};
    vt[10] = '{32'h30, 3'd4, 1'b0, 1'b0, 32'h0,        32'h1234F00D, 1'b0};
    vt[11] = '{32'h13, 3'd4, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
    vt[12] = '{32'h11, 3'd2, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
    vt[13] = '{32'h02, 3'd4, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[14] = '{32'h00, 3'd4, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
    for (int i = 0; i < 15; i++) begin
      do_req(vt[i].addr, vt[i].bytes, vt[i].wr, vt[i].sg, vt[i].wdata, 0, rd, er, lat);
      model(vt[i].addr, int'(vt[i].bytes), vt[i].wr, vt[i].sg, vt[i].wdata, erd, eer);
      check("vec_rdata", rd, vt[i].rdata);
      check("vec_error", {31'd0, er}, {31'd0, vt[i].err});
      check("vec_latency", lat, vt[i].err ? 32'd1 : 32'(LAT + 1));
    end

    do_req(32'h1 << (AW + 2), 3'd4, 1'b0, 1'b0, 32'h0, 5, rd, er, lat);
    check("oor_error", {31'd0, er}, 32'd1);
    check("oor_rdata", rd, 32'd0);
    check("oor_latency", lat, 32'd1);
    do_req(32'h0, 3'd3, 1'b1, 1'b0, 32'h12345678, 5, rd, er, lat);
    check("bytes3_error", {31'd0, er}, 32'd1);
    check("bytes3_rdata", rd, 32'd0);

    @(negedge clk);
    req_addr = 32'h40; req_bytes = 3'd4; req_write = 1'b1; req_signed = 1'b0;
    req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_req_ready", {31'd0, req_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    check("abort_error", {31'd0, resp_error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    do_req(32'h40, 3'd4, 1'b0, 1'b0, 32'h0, 0, rd, er, lat);
    model(32'h40, 4, 1'b0, 1'b0, 32'h0, erd, eer);
    check("abort_mem_kept", rd, erd);

    for (int it = 0; it < 300; it++) begin
      b = $urandom_range(0, 9);
      b = (b < 3) ? 1 : (b < 6) ? 2 : (b < 9) ? 4 : illegal_w[$urandom_range(0, 4)];
      a = ($urandom_range(0, 15) == 0) ? (32'h1000 + $urandom_range(0, 32'hFFFFF))
                                       : 32'($urandom_range(0, 255));
      req_signed = 1'b0;
      begin
        logic w, s;
        logic [31:0] wd;
        w  = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        wd = $urandom;
        do_req(a, 3'(b), w, s, wd, $urandom_range(0, 2), rd, er, lat);
        model(a, b, w, s, wd, erd, eer);
      end
      check("rnd_rdata", rd, erd);
      check("rnd_error", {31'd0, er}, {31'd0, eer});
      check("rnd_latency", lat, eer ? 32'd1 : 32'(LAT + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
